// File: rtl/fib_seq_ctrl.sv
// Job sequencer and 2-way round-robin arbiter wrapped around the 16-bit Fibonacci generator.
// Define FIB_SEQ_TIMEOUT_EN to build the WAIT-state watchdog.
module fib_seq_ctrl #(
   parameter int LEN_W   = 5,
   parameter int MAX_LEN = 24
`ifdef FIB_SEQ_TIMEOUT_EN
   ,
   parameter int TMO_CYC = 4
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req,
   input  logic [LEN_W-1:0] req_len0,
   input  logic [LEN_W-1:0] req_len1,
   output logic [1:0]       gnt,
   output logic             gen_clr,
   output logic             gen_en,
   input  logic             gen_valid,
   input  logic [15:0]      gen_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_data,
   output logic             out_id,
   output logic             out_last,
   output logic             done,
   output logic             err,
   output logic             busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_STEP,
      ST_WAIT,
      ST_HOLD
   } state_t;

   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

   state_t           state_q, state_d;
   logic             rr_q, rr_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             gen_clr_q, gen_clr_d;
   logic             gen_en_q, gen_en_d;
   logic             out_valid_q, out_valid_d;
   logic [15:0]      out_data_q, out_data_d;
   logic             out_id_q, out_id_d;
   logic             out_last_q, out_last_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic [1:0]       gnt_c;
   logic             sel_id;
   logic [LEN_W-1:0] sel_len;
   logic [LEN_W-1:0] cnt_inc;

`ifdef FIB_SEQ_TIMEOUT_EN
   localparam int             TMO_W    = $clog2(TMO_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

   assign cnt_inc = cnt_q + LEN_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rr_q        <= 1'b0;
         len_q       <= '0;
         cnt_q       <= '0;
         gen_clr_q   <= 1'b0;
         gen_en_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef FIB_SEQ_TIMEOUT_EN
         tmo_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         gen_clr_q   <= gen_clr_d;
         gen_en_q    <= gen_en_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
         err_q       <= err_d;
`ifdef FIB_SEQ_TIMEOUT_EN
         tmo_q       <= tmo_d;
`endif
      end
   end

   // Generator strobes are set on the transition into CLEAR/STEP so they line up with those states.
   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      gen_clr_d   = 1'b0;
      gen_en_d    = 1'b0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      err_d       = err_q;
      gnt_c       = 2'b00;
      sel_id      = 1'b0;
      sel_len     = req_len0;
`ifdef FIB_SEQ_TIMEOUT_EN
      tmo_d       = tmo_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (req != 2'b00) begin
               // The pointer only advances when both requesters compete.
               if (req == 2'b11) begin
                  sel_id = rr_q;
                  rr_d   = ~rr_q;
               end else begin
                  sel_id = req[1];
               end
               sel_len  = sel_id ? req_len1 : req_len0;
               gnt_c    = sel_id ? 2'b10 : 2'b01;
               out_id_d = sel_id;
               cnt_d    = '0;
               if (sel_len == '0) begin
                  len_d  = '0;
                  done_d = 1'b1;
               end else begin
                  if (sel_len > MAX_LEN_L) begin
                     len_d = MAX_LEN_L;
                     err_d = 1'b1;
                  end else begin
                     len_d = sel_len;
                  end
                  gen_clr_d = 1'b1;
                  state_d   = ST_CLEAR;
               end
            end
         end

         ST_CLEAR: begin
            gen_en_d = 1'b1;
            state_d  = ST_STEP;
         end

         ST_STEP: begin
`ifdef FIB_SEQ_TIMEOUT_EN
            tmo_d   = '0;
`endif
            state_d = ST_WAIT;
         end

         ST_WAIT: begin
            if (gen_valid) begin
               out_data_d  = gen_out;
               out_valid_d = 1'b1;
               out_last_d  = (cnt_inc == len_q);
               state_d     = ST_HOLD;
            end
`ifdef FIB_SEQ_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
`endif
         end

         ST_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               cnt_d       = cnt_inc;
               if (cnt_inc == len_q) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  gen_en_d = 1'b1;
                  state_d  = ST_STEP;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // Grant is decided combinationally in IDLE; masking with rst keeps it quiet during reset.
   assign gnt       = rst ? 2'b00 : gnt_c;
   assign gen_clr   = gen_clr_q;
   assign gen_en    = gen_en_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;
   assign out_last  = out_last_q;
   assign done      = done_q;
   assign err       = err_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Bench for fib_seq_ctrl: directed plan cases plus randomized traffic against a job-level model.
// Includes a behavioural Fibonacci generator driven by the controller's gen_clr/gen_en.
module tb_fib_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req = 2'b00;
   logic [4:0]  req_len0 = '0;
   logic [4:0]  req_len1 = '0;
   logic [1:0]  gnt;
   logic        gen_clr, gen_en;
   logic        gen_valid = 1'b0;
   logic [15:0] gen_out = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;
   logic        out_id, out_last, done, err, busy;

   int total = 0;
   int bad   = 0;

   fib_seq_ctrl dut (
      .clk(clk), .rst(rst), .req(req), .req_len0(req_len0), .req_len1(req_len1),
      .gnt(gnt), .gen_clr(gen_clr), .gen_en(gen_en), .gen_valid(gen_valid), .gen_out(gen_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
      .out_last(out_last), .done(done), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Generator: clear restarts at term 1; each enable yields the next term with a one-cycle valid.
   logic [15:0] fa = 16'd0;
   logic [15:0] fb = 16'd1;
   always @(posedge clk) begin
      if (gen_clr) begin
         fa <= 16'd0;
         fb <= 16'd1;
         gen_valid <= 1'b0;
      end else if (gen_en) begin
         gen_out   <= fb;
         fa        <= fb;
         fb        <= fa + fb;
         gen_valid <= 1'b1;
      end else begin
         gen_valid <= 1'b0;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int fib(input int k);
      int a, b, t;
      a = 0;
      b = 1;
      for (int i = 1; i < k; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return b;
   endfunction

   // Job-level model: grant rule, expected term list, and the latency/throughput timeline.
   int   cyc = 0;
   bit   m_active = 0;
   bit   m_rr = 0;
   bit   m_err = 0;
   bit   m_id = 0;
   int   m_valid_at = -1;
   int   m_done_cyc = -1;
   int   m_clr_cyc = -1;
   int   m_terms[$];
   logic [1:0] exp_gnt;
   bit   exp_valid, g_win, g_cont;
   int   g_len;
   logic [1:0] prev_gnt = 2'b00;
   int   obs_d[$];
   int   obs_i[$];
   int   obs_l[$];
   int   clr_cnt = 0, en_cnt = 0, ov_cnt = 0;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         checkOutput("rst_gnt", gnt, 0);
         checkOutput("rst_valid", out_valid, 0);
         checkOutput("rst_data", out_data, 0);
         checkOutput("rst_tag", {out_id, out_last}, 0);
         checkOutput("rst_gen", {gen_clr, gen_en}, 0);
         checkOutput("rst_done", done, 0);
         checkOutput("rst_err", err, 0);
         checkOutput("rst_busy", busy, 0);
         m_active = 0;
         m_rr = 0;
         m_err = 0;
         m_terms.delete();
         m_valid_at = -1;
         m_done_cyc = -1;
         m_clr_cyc = -1;
         prev_gnt = 2'b00;
      end else begin
         exp_gnt = 2'b00;
         g_win = 1'b0;
         g_cont = 1'b0;
         if (!m_active && req != 2'b00) begin
            g_cont = (req == 2'b11);
            g_win = g_cont ? m_rr : req[1];
            exp_gnt = g_win ? 2'b10 : 2'b01;
         end
         exp_valid = m_active && (cyc >= m_valid_at);

         checkOutput("gnt", gnt, exp_gnt);
         checkOutput("busy", busy, m_active);
         checkOutput("done", done, cyc == m_done_cyc);
         checkOutput("err", err, m_err);
         checkOutput("gen_clr", gen_clr, cyc == m_clr_cyc);
         checkOutput("gen_en", gen_en, m_active && (cyc == m_valid_at - 2));
         checkOutput("out_valid", out_valid, exp_valid);
         if (exp_valid) begin
            checkOutput("out_data", out_data, m_terms[0]);
            checkOutput("out_id", out_id, m_id);
            checkOutput("out_last", out_last, m_terms.size() == 1);
         end

         if (out_valid && out_ready) begin
            obs_d.push_back(int'(out_data));
            obs_i.push_back(int'(out_id));
            obs_l.push_back(int'(out_last));
         end
         if (gen_clr) clr_cnt++;
         if (gen_en) en_cnt++;
         if (out_valid) ov_cnt++;

         if (exp_valid && out_ready) begin
            void'(m_terms.pop_front());
            if (m_terms.size() == 0) begin
               m_active = 0;
               m_done_cyc = cyc + 1;
            end else begin
               m_valid_at = cyc + 3;
            end
         end

         if (exp_gnt != 2'b00) begin
            if (g_cont) m_rr = ~m_rr;
            g_len = g_win ? int'(req_len1) : int'(req_len0);
            if (g_len == 0) begin
               m_done_cyc = cyc + 1;
            end else begin
               if (g_len > 24) begin
                  g_len = 24;
                  m_err = 1;
               end
               m_terms.delete();
               for (int k = 1; k <= g_len; k++) m_terms.push_back(fib(k));
               m_id = g_win;
               m_active = 1;
               m_clr_cyc = cyc + 1;
               m_valid_at = cyc + 4;
            end
         end
         prev_gnt = gnt;
      end
   end

   task automatic applyStimulus(input logic [1:0] r, input logic [4:0] l0, input logic [4:0] l1,
                                input logic rdy);
      @(posedge clk);
      #1;
      req = r;
      req_len0 = l0;
      req_len1 = l1;
      out_ready = rdy;
   endtask

   task automatic waitDone(input int maxc);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done !== 1'b1 && n < maxc);
      if (done !== 1'b1) checkOutput("done_timeout", 0, 1);
      #1;
   endtask

   task automatic startJob(input bit id, input int len, output logic [1:0] g);
      int n;
      if (id) applyStimulus(2'b10, req_len0, 5'(len), out_ready);
      else    applyStimulus(2'b01, 5'(len), req_len1, out_ready);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (gnt[id] !== 1'b1 && n < 50);
      g = gnt;
      if (gnt[id] !== 1'b1) checkOutput("grant_timeout", 0, 1);
      applyStimulus(2'b00, req_len0, req_len1, out_ready);
   endtask

   task automatic runJob(input bit id, input int len, output logic [1:0] g);
      startJob(id, len, g);
      waitDone(200);
   endtask

   task automatic waitObs(input int cnt);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (obs_d.size() < cnt && n < 100);
      if (obs_d.size() < cnt) checkOutput("obs_timeout", obs_d.size(), cnt);
   endtask

   task automatic waitValid();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (out_valid !== 1'b1 && n < 50);
      if (out_valid !== 1'b1) checkOutput("valid_timeout", 0, 1);
   endtask

   int ed[$];
   int ei[$];
   int el[$];

   task automatic checkLog(input string tag);
      int ad, ai, al;
      checkOutput({tag, "_count"}, obs_d.size(), ed.size());
      for (int i = 0; i < ed.size(); i++) begin
         ad = (i < obs_d.size()) ? obs_d[i] : -1;
         ai = (i < obs_i.size()) ? obs_i[i] : -1;
         al = (i < obs_l.size()) ? obs_l[i] : -1;
         checkOutput($sformatf("%s_data%0d", tag, i), ad, ed[i]);
         checkOutput($sformatf("%s_id%0d", tag, i), ai, ei[i]);
         checkOutput($sformatf("%s_last%0d", tag, i), al, el[i]);
      end
   endtask

   task automatic clearObs();
      obs_d.delete();
      obs_i.delete();
      obs_l.delete();
   endtask

   function automatic logic [4:0] randLen();
      int r;
      r = $urandom_range(0, 99);
      if (r < 8)       return 5'd0;
      else if (r < 14) return 5'($urandom_range(25, 31));
      else if (r < 18) return 5'd24;
      else             return 5'($urandom_range(1, 7));
   endfunction

   logic [1:0] seen;
   bit         order[$];
   int         n;

   initial begin
      checkOutput("model_fib6", fib(6), 8);
      checkOutput("model_fib24", fib(24), 46368);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Single requester, six terms, no backpressure.
      clearObs();
      runJob(1'b0, 6, seen);
      checkOutput("t1_gnt", seen, 2'b01);
      ed = '{1, 1, 2, 3, 5, 8};
      ei = '{0, 0, 0, 0, 0, 0};
      el = '{0, 0, 0, 0, 0, 1};
      checkLog("t1");
      checkOutput("t1_err", err, 0);

      // Both requesters held: alternating grants starting with requester 0.
      clearObs();
      order.delete();
      applyStimulus(2'b11, 5'd2, 5'd3, 1'b1);
      n = 0;
      while (order.size() < 4 && n < 300) begin
         @(negedge clk);
         n++;
         if (gnt != 2'b00) order.push_back(gnt[1]);
      end
      applyStimulus(2'b00, 5'd2, 5'd3, 1'b1);
      waitDone(100);
      checkOutput("t2_grants", order.size(), 4);
      for (int i = 0; i < 4 && i < order.size(); i++)
         checkOutput($sformatf("t2_order%0d", i), order[i], i % 2);
      ed = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
      ei = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1};
      el = '{0, 1, 0, 0, 1, 0, 1, 0, 0, 1};
      checkLog("t2");

      // Over-long job is clamped to 24 terms and flags err.
      clearObs();
      runJob(1'b0, 31, seen);
      checkOutput("t3_count", obs_d.size(), 24);
      if (obs_d.size() > 0) begin
         checkOutput("t3_final", obs_d[$], 46368);
         checkOutput("t3_last", obs_l[$], 1);
      end
      checkOutput("t3_err", err, 1);

      // Zero-length job: grant and done only.
      clearObs();
      clr_cnt = 0;
      en_cnt = 0;
      ov_cnt = 0;
      runJob(1'b1, 0, seen);
      repeat (3) @(negedge clk);
      #1;
      checkOutput("t4_gnt", seen, 2'b10);
      checkOutput("t4_gen_pulses", clr_cnt + en_cnt, 0);
      checkOutput("t4_valids", ov_cnt, 0);
      checkOutput("t4_err_sticky", err, 1);

      // Backpressure on the third term.
      clearObs();
      startJob(1'b0, 5, seen);
      waitObs(2);
      applyStimulus(2'b00, req_len0, req_len1, 1'b0);
      waitValid();
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         checkOutput($sformatf("t5_hold%0d", k), out_data, 2);
         checkOutput($sformatf("t5_gen_en%0d", k), gen_en, 0);
      end
      applyStimulus(2'b00, req_len0, req_len1, 1'b1);
      waitDone(100);
      ed = '{1, 1, 2, 3, 5};
      ei = '{0, 0, 0, 0, 0};
      el = '{0, 0, 0, 0, 1};
      checkLog("t5");

      // Reset while holding term 2, then a fresh job.
      clearObs();
      startJob(1'b0, 4, seen);
      waitObs(1);
      applyStimulus(2'b00, req_len0, req_len1, 1'b0);
      waitValid();
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("t6_valid", out_valid, 0);
      checkOutput("t6_data", out_data, 0);
      checkOutput("t6_busy", busy, 0);
      checkOutput("t6_err", err, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      clearObs();
      out_ready = 1'b1;
      runJob(1'b0, 3, seen);
      ed = '{1, 1, 2};
      ei = '{0, 0, 0};
      el = '{0, 0, 1};
      checkLog("t6");

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         rst = (c == 1500);
         for (int i = 0; i < 2; i++) begin
            if (req[i]) begin
               if (prev_gnt[i]) begin
                  if ($urandom_range(0, 9) < 7) req[i] = 1'b0;
               end else if ($urandom_range(0, 19) == 0) begin
                  req[i] = 1'b0;
               end
            end else if ($urandom_range(0, 9) < 3) begin
               req[i] = 1'b1;
               if (i == 0) req_len0 = randLen();
               else        req_len1 = randLen();
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
      end
      applyStimulus(2'b00, req_len0, req_len1, 1'b1);
      repeat (150) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
